// File: rtl/alu_seq_pipe_if.sv
// Request/response bundle between issue/decode, the ALU and writeback.
// master = surrounding pipeline, slave = ALU.
interface alu_seq_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             z;
    logic             cout;
    logic             of;
    logic             illegal;

    modport master (
        output in_valid, alu_op, in1, in2, out_ready,
        input  in_ready, out_valid, result, z, cout, of, illegal
    );

    modport slave (
        input  in_valid, alu_op, in1, in2, out_ready,
        output in_ready, out_valid, result, z, cout, of, illegal
    );
endinterface

// File: rtl/alu_seq_pipe.sv
// Registered ALU, one op in flight; iterative MUL when ALU_SEQ_MUL_EN is defined.
// Latency 1 cycle (MUL: WIDTH cycles).
// in_ready drops while a result is stalled (out_valid && !out_ready) or a MUL is running.
module alu_seq_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_pipe_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SRL  = 4'd6,  OP_SLL  = 4'd7;
    localparam logic [3:0] OP_ADDU = 4'd8,  OP_SUBU = 4'd9,  OP_SRA  = 4'd10, OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    logic             accept, start_mul, mul_done, load;
    logic             is_sub;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] b_eff, sra_res, mul_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout, alu_of, alu_ill;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, cout_q, of_q, illegal_q;
    logic             cout_d, of_d, illegal_d;

    assign accept  = bus.in_valid && bus.in_ready;
    assign shamt   = bus.in2[SHW-1:0];
    assign is_sub  = (bus.alu_op == OP_SUB) || (bus.alu_op == OP_SUBU);
    assign b_eff   = is_sub ? ~bus.in2 : bus.in2;
    assign sum     = {1'b0, bus.in1} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
    assign sra_res = $signed(bus.in1) >>> shamt;

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_of   = 1'b0;
        alu_ill  = 1'b0;
        case (bus.alu_op)
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_of   = (bus.in1[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_ADDU, OP_SUBU: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
            end
            OP_AND:  alu_res = bus.in1 & bus.in2;
            OP_OR:   alu_res = bus.in1 | bus.in2;
            OP_XOR:  alu_res = bus.in1 ^ bus.in2;
            OP_NOR:  alu_res = ~(bus.in1 | bus.in2);
            OP_SRL:  alu_res = bus.in1 >> shamt;
            OP_SLL:  alu_res = bus.in1 << shamt;
            OP_SRA:  alu_res = sra_res;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.in1 < bus.in2};
`ifdef ALU_SEQ_MUL_EN
            4'd13:   alu_res = '0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;

    assign start_mul = accept && (bus.alu_op == 4'd13);
    assign mul_done  = (state_q == S_BUSY) && (cnt_q == SHW'(WIDTH-2));
    assign mul_res   = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_mul) state_d = S_BUSY;
            S_BUSY:  if (mul_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    end

    // Partial product for bit 0 is taken in the accept cycle, so WIDTH-1 BUSY steps
    // finish the product and the result shows up exactly WIDTH cycles after accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_mul) begin
            cnt_q    <= '0;
            acc_q    <= bus.in2[0] ? bus.in1 : '0;
            mcand_q  <= bus.in1 << 1;
            mplier_q <= bus.in2 >> 1;
        end else if (state_q == S_BUSY) begin
            cnt_q    <= cnt_q + SHW'(1);
            acc_q    <= mul_res;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`else
    assign start_mul    = 1'b0;
    assign mul_done     = 1'b0;
    assign mul_res      = '0;
    assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

    assign load = (accept && !start_mul) || mul_done;

    always_comb begin
        result_d    = alu_res;
        cout_d      = alu_cout;
        of_d        = alu_of;
        illegal_d   = alu_ill;
        out_valid_d = out_valid_q && !bus.out_ready;
        if (mul_done) begin
            result_d  = mul_res;
            cout_d    = 1'b0;
            of_d      = 1'b0;
            illegal_d = 1'b0;
        end
        if (load) out_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b0;
            cout_q      <= 1'b0;
            of_q        <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                result_q  <= result_d;
                z_q       <= (result_d == '0);
                cout_q    <= cout_d;
                of_q      <= of_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.z         = z_q;
    assign bus.cout      = cout_q;
    assign bus.of        = of_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq_pipe.sv
// Scoreboard bench for alu_seq_pipe: arithmetic reference model plus known-answer vectors.
module tb_alu_seq_pipe;
    typedef struct {
        logic [31:0] res;
        logic        z, c, o, ill;
        int          lat;
        int          due;
        bit          seen;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t kat_e;
    exp_t mon_e;
    bit   kat_en = 1'b0;
    bit   rand_rdy = 1'b0;

    alu_seq_pipe_if #(.WIDTH(32)) bif ();
    alu_seq_pipe #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sbv, d;
        longint unsigned u;
        e.res = '0; e.c = 1'b0; e.o = 1'b0; e.ill = 1'b0; e.lat = 1; e.due = 0; e.seen = 1'b0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            4'd0, 4'd8: begin
                u = {32'b0, a} + {32'b0, b};
                e.res = u[31:0];
                e.c   = u[32];
                d = sa + sbv;
                if (op == 4'd0) e.o = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            4'd1, 4'd9: begin
                e.res = a - b;
                e.c   = (a >= b);
                d = sa - sbv;
                if (op == 4'd1) e.o = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = ~(a | b);
            4'd6:  e.res = a >> b[4:0];
            4'd7:  e.res = a << b[4:0];
            4'd10: e.res = 32'($signed(a) >>> b[4:0]);
            4'd11: e.res = (sa < sbv) ? 32'd1 : 32'd0;
            4'd12: e.res = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MUL_EN
            4'd13: begin
                u = {32'b0, a} * {32'b0, b};
                e.res = u[31:0];
                e.lat = 32;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor: compares outputs, checks latency, and pushes expectations on every accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    if (!sb[0].seen) begin
                        chk("latency", cyc, sb[0].due);
                        sb[0].seen = 1'b1;
                    end
                    chk("result_flags", {bif.result, bif.z, bif.cout, bif.of, bif.illegal},
                        {sb[0].res, sb[0].z, sb[0].c, sb[0].o, sb[0].ill});
                    if (bif.out_ready) void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && !sb[0].seen && cyc >= sb[0].due) begin
                chk("late_out_valid", cyc, sb[0].due);
                sb[0].seen = 1'b1;
            end
            if (bif.in_valid && bif.in_ready) begin
                mon_e = kat_en ? kat_e : model(bif.alu_op, bif.in1, bif.in2);
                mon_e.due  = cyc + mon_e.lat;
                mon_e.seen = 1'b0;
                sb.push_back(mon_e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bif.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int tries);
        bit ok;
        bif.in_valid = 1'b1;
        bif.alu_op   = op;
        bif.in1      = a;
        bif.in2      = b;
        tries = 0;
        forever begin
            @(negedge clk);
            tries++;
            ok = bif.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            if (tries >= 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic set_kat(input logic [31:0] r, input logic c, input logic o, input logic ill, input int lat);
        kat_e.res = r; kat_e.z = (r == 32'd0); kat_e.c = c; kat_e.o = o; kat_e.ill = ill;
        kat_e.lat = lat; kat_e.due = 0; kat_e.seen = 1'b0;
        kat_en = 1'b1;
    endtask

    task automatic issue_kat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] r, input logic c, input logic o, input logic ill, input int lat);
        int t;
        set_kat(r, c, o, ill, lat);
        issue(op, a, b, t);
        kat_en = 1'b0;
    endtask

    task automatic idle(input int n);
        bif.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t;
        logic [3:0] op;
        rst_n = 1'b0;
        bif.in_valid = 1'b0; bif.alu_op = 4'd0; bif.in1 = '0; bif.in2 = '0; bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {bif.out_valid, bif.result, bif.z, bif.cout, bif.of, bif.illegal}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bif.in_ready, 1);
        @(posedge clk); #1;

        // Known-answer vectors, consumer always ready.
        bif.out_ready = 1'b1;
        issue_kat(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
        issue_kat(4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1);
        issue_kat(4'd1,  32'h0000_0005, 32'h0000_0001, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1);
        issue_kat(4'd10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1);
        issue_kat(4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1);
        issue_kat(4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1);
        issue_kat(4'd12, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1);
        issue_kat(4'd14, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
        issue_kat(4'd13, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 32);
`else
        issue_kat(4'd13, 32'h0001_0000, 32'h0001_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
`endif
        idle(40);

        // Backpressure: result held for 5 cycles, second request waits.
        bif.out_ready = 1'b0;
        issue_kat(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
        set_kat(32'h0000_0004, 1'b1, 1'b0, 1'b0, 1);
        bif.alu_op = 4'd1; bif.in1 = 32'd5; bif.in2 = 32'd1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", {bif.in_ready, bif.out_valid}, 2'b01);
        end
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", bif.in_ready, 1);
        @(posedge clk); #1;
        kat_en = 1'b0;
        idle(3);

        // Streaming: 8 logic ops back to back, each must be accepted first try.
        for (int i = 0; i < 8; i++) begin
            op = 4'(2 + (i % 3));
            issue(op, $urandom, $urandom, t);
            chk("stream_accept_tries", t, 1);
        end
        idle(3);

        // Reset in the middle of an operation (MUL busy, or stalled illegal result).
        bif.out_ready = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        issue_kat(4'd13, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 32);
`else
        issue_kat(4'd13, 32'h0001_0000, 32'h0001_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
`endif
        idle(9);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("midop_reset_outputs", {bif.in_ready, bif.out_valid, bif.result, bif.z, bif.cout, bif.of, bif.illegal},
            {1'b1, 37'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        bif.out_ready = 1'b1;
        @(negedge clk);
        chk("midop_ready_after_reset", bif.in_ready, 1);
        idle(40);

        // Random traffic with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(op, pick(), pick(), t);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        bif.in_valid = 1'b0;
        rand_rdy = 1'b0;
        bif.out_ready = 1'b1;
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        idle(2);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
